// File: rtl/wm_phase_timer.sv
// wm_phase_timer: phase timer and watchdog for the washing-machine controller.
// Watches the controller's one-hot operation outputs, counts ticks in each
// phase, and raises the timeout (fill/heat) or completion (wash/rinse/spin)
// levels when the phase limit expires.
// Optional feature: define WM_PAUSE_EN to add sig_Lid_Closed, which pauses
// wash/rinse/spin counting while the lid is open.
module wm_phase_timer #(
    parameter int unsigned CLK_PER_TICK = 1000,
    parameter int unsigned FILL_TIMEOUT = 120,
    parameter int unsigned HEAT_TIMEOUT = 300,
    parameter int unsigned WASH_TICKS   = 600,
    parameter int unsigned RINSE_TICKS  = 300,
    parameter int unsigned SPIN_TICKS   = 200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fill_Water_Operation,
    input  logic        heat_Water_Operation,
    input  logic        wash_Operation,
    input  logic        rinse_Operation,
    input  logic        spin_Operation,
    input  logic        fault,
`ifdef WM_PAUSE_EN
    input  logic        sig_Lid_Closed,
`endif
    output logic        sig_Time_Out,
    output logic        sig_Wash_Completed,
    output logic        sig_Rinse_Completed,
    output logic        sig_Spin_Completed,
    output logic [15:0] remaining,
    output logic        phase_Error
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PH_W  = 3;
    localparam int unsigned OP_W  = 5;

    localparam logic [PH_W-1:0] PH_IDLE  = 3'd0;
    localparam logic [PH_W-1:0] PH_FILL  = 3'd1;
    localparam logic [PH_W-1:0] PH_HEAT  = 3'd2;
    localparam logic [PH_W-1:0] PH_WASH  = 3'd3;
    localparam logic [PH_W-1:0] PH_RINSE = 3'd4;
    localparam logic [PH_W-1:0] PH_SPIN  = 3'd5;

    // A limit of zero behaves as one tick.
    localparam logic [CNT_W-1:0] LIM_FILL  = (CNT_W'(FILL_TIMEOUT) == '0) ? CNT_W'(1) : CNT_W'(FILL_TIMEOUT);
    localparam logic [CNT_W-1:0] LIM_HEAT  = (CNT_W'(HEAT_TIMEOUT) == '0) ? CNT_W'(1) : CNT_W'(HEAT_TIMEOUT);
    localparam logic [CNT_W-1:0] LIM_WASH  = (CNT_W'(WASH_TICKS)   == '0) ? CNT_W'(1) : CNT_W'(WASH_TICKS);
    localparam logic [CNT_W-1:0] LIM_RINSE = (CNT_W'(RINSE_TICKS)  == '0) ? CNT_W'(1) : CNT_W'(RINSE_TICKS);
    localparam logic [CNT_W-1:0] LIM_SPIN  = (CNT_W'(SPIN_TICKS)   == '0) ? CNT_W'(1) : CNT_W'(SPIN_TICKS);

    // Last prescaler value before a tick; CLK_PER_TICK of 0 or 1 ticks every clock.
    localparam logic [CNT_W-1:0] PRE_MAX = (CLK_PER_TICK <= 1) ? '0 : CNT_W'(CLK_PER_TICK - 1);

    logic [PH_W-1:0]  r_phase;
    logic [CNT_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_time_out;
    logic             r_wash_cmp;
    logic             r_rinse_cmp;
    logic             r_spin_cmp;
    logic             r_phase_err;

    logic [OP_W-1:0]  w_op_vec;
    logic [2:0]       w_op_count;
    logic             w_multi;
    logic [PH_W-1:0]  w_phase_d;
    logic [CNT_W-1:0] w_lim_d;
    logic             w_hold;
    logic [PH_W-1:0]  w_phase_nxt;
    logic [CNT_W-1:0] w_pre_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_done_nxt;

    // Decode the requested phase from the operation inputs; fault forces IDLE.
    always_comb begin
        w_op_vec   = {spin_Operation, rinse_Operation, wash_Operation,
                      heat_Water_Operation, fill_Water_Operation};
        w_op_count = '0;
        for (int i = 0; i < int'(OP_W); i++) begin
            w_op_count = w_op_count + 3'(w_op_vec[i]);
        end
        w_multi   = (w_op_count > 3'd1);
        w_phase_d = PH_IDLE;
        if (!fault) begin
            case (w_op_vec)
                5'b00001: w_phase_d = PH_FILL;
                5'b00010: w_phase_d = PH_HEAT;
                5'b00100: w_phase_d = PH_WASH;
                5'b01000: w_phase_d = PH_RINSE;
                5'b10000: w_phase_d = PH_SPIN;
                default:  w_phase_d = PH_IDLE;
            endcase
        end
    end

    // Limit loaded when entering the decoded phase.
    always_comb begin
        w_lim_d = '0;
        case (w_phase_d)
            PH_FILL:  w_lim_d = LIM_FILL;
            PH_HEAT:  w_lim_d = LIM_HEAT;
            PH_WASH:  w_lim_d = LIM_WASH;
            PH_RINSE: w_lim_d = LIM_RINSE;
            PH_SPIN:  w_lim_d = LIM_SPIN;
            default:  w_lim_d = '0;
        endcase
    end

    // Pause condition: open lid freezes wash/rinse/spin; fill and heat keep running.
`ifdef WM_PAUSE_EN
    always_comb begin
        w_hold = 1'b0;
        if (!sig_Lid_Closed &&
            ((r_phase == PH_WASH) || (r_phase == PH_RINSE) || (r_phase == PH_SPIN))) begin
            w_hold = 1'b1;
        end
    end
`else
    always_comb begin
        w_hold = 1'b0;
    end
`endif

    // Next-state: reload on phase change, otherwise prescale and count down until done.
    always_comb begin
        w_phase_nxt = r_phase;
        w_pre_nxt   = r_pre;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = r_done;
        if (w_phase_d != r_phase) begin
            w_phase_nxt = w_phase_d;
            w_cnt_nxt   = w_lim_d;
            w_pre_nxt   = '0;
            w_done_nxt  = 1'b0;
        end else if ((r_phase != PH_IDLE) && !r_done && !w_hold) begin
            if (r_pre == PRE_MAX) begin
                w_pre_nxt = '0;
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
                if (r_cnt <= CNT_W'(1)) begin
                    w_done_nxt = 1'b1;
                end
            end else begin
                w_pre_nxt = r_pre + CNT_W'(1);
            end
        end
    end

    // State and registered output levels, decoded from the next phase/done so
    // the flags line up with the cycle in which done becomes visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase     <= PH_IDLE;
            r_pre       <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_time_out  <= 1'b0;
            r_wash_cmp  <= 1'b0;
            r_rinse_cmp <= 1'b0;
            r_spin_cmp  <= 1'b0;
            r_phase_err <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_pre       <= w_pre_nxt;
            r_cnt       <= w_cnt_nxt;
            r_done      <= w_done_nxt;
            r_time_out  <= w_done_nxt && ((w_phase_nxt == PH_FILL) || (w_phase_nxt == PH_HEAT));
            r_wash_cmp  <= w_done_nxt && (w_phase_nxt == PH_WASH);
            r_rinse_cmp <= w_done_nxt && (w_phase_nxt == PH_RINSE);
            r_spin_cmp  <= w_done_nxt && (w_phase_nxt == PH_SPIN);
            r_phase_err <= w_multi;
        end
    end

    assign sig_Time_Out        = r_time_out;
    assign sig_Wash_Completed  = r_wash_cmp;
    assign sig_Rinse_Completed = r_rinse_cmp;
    assign sig_Spin_Completed  = r_spin_cmp;
    assign remaining           = r_cnt;
    assign phase_Error         = r_phase_err;

endmodule
